hilo_mult_sequencer: RTL and testbench

//  Multi-cycle iterative multiplier and owner of the architectural HI/LO registers.
//  It is driven by the EX stage for MULT, MULTU, MADD, MSUB, MTHI, MTLO, MFHI and MFLO.
//  It serialises these ops over a shared shift-add datapath.
//  It raises Stall to freeze IF/ID/EX while HI/LO is being produced.

---
 rtl/hilo_mult_sequencer.sv | 174 +++++++++++++++++
 tb/tb_hilo_mult_sequencer.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/hilo_mult_sequencer.sv
// Iterative shift-add multiplier that owns the architectural HI/LO pair (MULT/MULTU/MADD/MSUB/MTHI/MTLO/MFHI/MFLO).
// Optional macro ZERO_SKIP_EN: a multiply with a zero operand bypasses the MUL iterations.
module hilo_mult_sequencer #(
    parameter int BITS_PER_CYCLE = 2
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        Op_Valid,
    input  logic [2:0]  Op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        Flush,
    output logic        Stall,
    output logic        Busy,
    output logic [31:0] HiLo_Out,
    output logic        Result_Valid,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int         STEPS     = 32 / BITS_PER_CYCLE;
    localparam logic [5:0] LAST_STEP = 6'(STEPS - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_ACC  = 2'd3;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_MADD  = 3'b010;
    localparam logic [2:0] OP_MSUB  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;
    localparam logic [2:0] OP_MFHI  = 3'b110;

    logic [1:0]  state_q, state_d;
    logic [2:0]  op_q, op_d;
    logic        sign_q, sign_d;
    logic [63:0] mcand_q, mcand_d;
    logic [32:0] mplier_q, mplier_d;
    logic [63:0] prod_q, prod_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic        accept;
    logic        signed_op;
    logic        zero_skip;
    logic [32:0] a_ext, b_ext, a_mag, b_mag;
    logic [63:0] fixed_prod;
    logic [63:0] hilo_sum, hilo_diff;

    function automatic logic [63:0] partial_sum(input logic [63:0] mc,
                                                input logic [BITS_PER_CYCLE-1:0] bits);
        logic [63:0] s;
        s = '0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            if (bits[i]) s = s + (mc << i);
        end
        return s;
    endfunction

    assign Busy   = (state_q != S_IDLE);
    assign Stall  = Op_Valid & Busy & ~Flush;
    assign accept = Op_Valid & ~Busy & ~Flush;

    assign Result_Valid = accept & Op[2] & Op[1];
    assign HiLo_Out     = Result_Valid ? ((Op == OP_MFHI) ? hi_q : lo_q) : 32'd0;
    assign HI = hi_q;
    assign LO = lo_q;

    // 33-bit magnitudes so that -2^31 keeps its full magnitude
    assign signed_op = (Op != OP_MULTU);
    assign a_ext     = {signed_op & A[31], A};
    assign b_ext     = {signed_op & B[31], B};
    assign a_mag     = a_ext[32] ? (33'd0 - a_ext) : a_ext;
    assign b_mag     = b_ext[32] ? (33'd0 - b_ext) : b_ext;

`ifdef ZERO_SKIP_EN
    assign zero_skip = (A == 32'd0) | (B == 32'd0);
`else
    assign zero_skip = 1'b0;
`endif

    assign fixed_prod = sign_q ? (64'd0 - prod_q) : prod_q;
    assign hilo_sum   = {hi_q, lo_q} + prod_q;
    assign hilo_diff  = {hi_q, lo_q} - prod_q;

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        sign_d   = sign_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        prod_d   = prod_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (!Op[2]) begin
                        op_d     = Op;
                        sign_d   = signed_op & (A[31] ^ B[31]);
                        mcand_d  = {31'd0, a_mag};
                        mplier_d = b_mag;
                        prod_d   = '0;
                        cnt_d    = '0;
                        state_d  = zero_skip ? S_FIX : S_MUL;
                    end else if (Op == OP_MTHI) begin
                        hi_d = A;
                    end else if (Op == OP_MTLO) begin
                        lo_d = A;
                    end
                end
            end
            S_MUL: begin
                prod_d   = prod_q + partial_sum(mcand_q, mplier_q[BITS_PER_CYCLE-1:0]);
                mcand_d  = mcand_q << BITS_PER_CYCLE;
                mplier_d = mplier_q >> BITS_PER_CYCLE;
                cnt_d    = cnt_q + 6'd1;
                if (cnt_q == LAST_STEP) state_d = S_FIX;
            end
            S_FIX: begin
                if (op_q == OP_MADD || op_q == OP_MSUB) begin
                    prod_d  = fixed_prod;
                    state_d = S_ACC;
                end else begin
                    {hi_d, lo_d} = fixed_prod;
                    state_d      = S_IDLE;
                end
            end
            S_ACC: begin
                {hi_d, lo_d} = (op_q == OP_MSUB) ? hilo_diff : hilo_sum;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Flush aborts any in-flight op without touching HI/LO
        if (Flush) begin
            state_d = S_IDLE;
            hi_d    = hi_q;
            lo_d    = lo_q;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state_q  <= S_IDLE;
            op_q     <= OP_MULT;
            sign_q   <= 1'b0;
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            sign_q   <= sign_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

endmodule

// File: tb/tb_hilo_mult_sequencer.sv
// Bench for hilo_mult_sequencer: op-level reference model checked every cycle plus directed literal checks.
module tb_hilo_mult_sequencer;

    localparam int BPC   = 2;
    localparam int STEPS = 32 / BPC;
`ifdef ZERO_SKIP_EN
    localparam bit ZS = 1'b1;
`else
    localparam bit ZS = 1'b0;
`endif

    localparam logic [2:0] MULT = 3'b000, MULTU = 3'b001, MADD = 3'b010, MSUB = 3'b011;
    localparam logic [2:0] MTHI = 3'b100, MTLO = 3'b101, MFHI = 3'b110, MFLO = 3'b111;

    logic        Clk = 1'b0;
    logic        Rst_n = 1'b0;
    logic        Op_Valid = 1'b0;
    logic [2:0]  Op = 3'b000;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic        Flush = 1'b0;
    logic        Stall, Busy, Result_Valid;
    logic [31:0] HiLo_Out, HI, LO;

    int vectors = 0;
    int errors  = 0;

    hilo_mult_sequencer #(.BITS_PER_CYCLE(BPC)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .Op_Valid(Op_Valid), .Op(Op), .A(A), .B(B),
        .Flush(Flush), .Stall(Stall), .Busy(Busy), .HiLo_Out(HiLo_Out),
        .Result_Valid(Result_Valid), .HI(HI), .LO(LO)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: an op is accepted, results land after its latency, flush/reset cancel it.
    logic [31:0] m_hi = '0, m_lo = '0;
    int          m_left = 0;
    int          m_kind = 0;
    logic [63:0] m_pend = '0;
    logic [63:0] sa, sb;

    always @(posedge Clk) begin
        if (!Rst_n) begin
            m_hi = '0; m_lo = '0; m_left = 0;
        end else if (Flush) begin
            m_left = 0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                case (m_kind)
                    0: {m_hi, m_lo} = m_pend;
                    1: {m_hi, m_lo} = {m_hi, m_lo} + m_pend;
                    default: {m_hi, m_lo} = {m_hi, m_lo} - m_pend;
                endcase
            end
        end else if (Op_Valid) begin
            sa = {{32{A[31]}}, A};
            sb = {{32{B[31]}}, B};
            case (Op)
                MULT, MULTU, MADD, MSUB: begin
                    m_pend = (Op == MULTU) ? ({32'd0, A} * {32'd0, B}) : (sa * sb);
                    m_kind = (Op == MADD) ? 1 : (Op == MSUB) ? 2 : 0;
                    m_left = (ZS && (A == 0 || B == 0)) ? 1 : STEPS + 1;
                    if (m_kind != 0) m_left++;
                end
                MTHI: m_hi = A;
                MTLO: m_lo = A;
                default: ;
            endcase
        end
    end

    always @(negedge Clk) begin
        logic mb, exp_rv;
        mb     = (m_left > 0);
        exp_rv = Op_Valid & ~mb & ~Flush & Op[2] & Op[1];
        chk("busy", Busy, mb);
        chk("stall", Stall, Op_Valid & mb & ~Flush);
        chk("result_valid", Result_Valid, exp_rv);
        chk("hilo_out", HiLo_Out, exp_rv ? ((Op == MFHI) ? m_hi : m_lo) : 32'd0);
        chk("hi", HI, m_hi);
        chk("lo", LO, m_lo);
    end

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(posedge Clk); #1;
        Op_Valid = 1'b1; Op = op; A = a; B = b;
        @(posedge Clk); #1;
        Op_Valid = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int exp_cycles);
        int  n;
        bit  done;
        n = 0; done = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge Clk);
            if (!Busy) begin done = 1; break; end
            n++;
        end
        chk({name, "_done"}, done, 1'b1);
        chk({name, "_busy_cycles"}, n, exp_cycles);
    endtask

    initial begin
        int  n;
        bit  seen;
        repeat (2) @(posedge Clk);
        #1 Rst_n = 1'b1;
        @(negedge Clk);
        chk("rst_hi", HI, 0); chk("rst_lo", LO, 0); chk("rst_busy", Busy, 0);
        chk("rst_stall", Stall, 0); chk("rst_rv", Result_Valid, 0);

        issue(MULT, 32'hFFFF_FFFF, 32'h2);
        wait_idle("mult", 17);
        chk("mult_hi", HI, 32'hFFFF_FFFF); chk("mult_lo", LO, 32'hFFFF_FFFE);
        issue(MULTU, 32'hFFFF_FFFF, 32'h2);
        wait_idle("multu", 17);
        chk("multu_hi", HI, 32'h1); chk("multu_lo", LO, 32'hFFFF_FFFE);
        issue(MULT, 32'h8000_0000, 32'h8000_0000);
        wait_idle("mult_min", 17);
        chk("min_hi", HI, 32'h4000_0000); chk("min_lo", LO, 32'h0);

        issue(MTHI, 32'h0, 32'h0);
        issue(MTLO, 32'h5, 32'h0);
        issue(MADD, 32'h3, 32'h4);
        wait_idle("madd", 18);
        chk("madd_hi", HI, 32'h0); chk("madd_lo", LO, 32'h11);
        issue(MSUB, 32'hFFFF_FFFF, 32'h12);
        wait_idle("msub", 18);
        chk("msub_hi", HI, 32'h0); chk("msub_lo", LO, 32'h23);

        // MULT followed directly by a held MFLO
        @(posedge Clk); #1;
        Op_Valid = 1'b1; Op = MULT; A = 32'd7; B = 32'd6;
        @(posedge Clk); #1;
        Op = MFLO;
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge Clk);
            if (Result_Valid) begin seen = 1; break; end
        end
        chk("mflo_seen", seen, 1'b1);
        chk("mflo_data", HiLo_Out, 32'h2A);
        @(posedge Clk); #1 Op_Valid = 1'b0;

        issue(MTHI, 32'h55, 32'h0);
        issue(MTLO, 32'h55, 32'h0);
        issue(MADD, 32'h2, 32'h2);
        repeat (4) @(posedge Clk);
        #1 Flush = 1'b1;
        @(posedge Clk); #1 Flush = 1'b0;
        @(negedge Clk);
        chk("flush_busy", Busy, 0); chk("flush_hi", HI, 32'h55); chk("flush_lo", LO, 32'h55);
        @(posedge Clk); #1;
        Op_Valid = 1'b1; Flush = 1'b1; Op = MTHI; A = 32'h99;
        @(posedge Clk); #1;
        Op_Valid = 1'b0; Flush = 1'b0;
        @(negedge Clk);
        chk("flush_idle_hi", HI, 32'h55); chk("flush_idle_busy", Busy, 0);

        issue(MULT, 32'h0, 32'h1234);
        wait_idle("zero", ZS ? 1 : 17);
        chk("zero_hi", HI, 32'h0); chk("zero_lo", LO, 32'h0);

        issue(MTHI, 32'h77, 32'h0);
        issue(MULT, 32'h3, 32'h5);
        repeat (3) @(posedge Clk);
        #1 Rst_n = 1'b0;
        @(posedge Clk); #1 Rst_n = 1'b1;
        @(negedge Clk);
        chk("midrst_busy", Busy, 0); chk("midrst_hi", HI, 0); chk("midrst_lo", LO, 0);

        repeat (2) @(negedge Clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
